// File: rtl/parity_check_pkg.sv
// Shared definitions for the streamed parity checker.
//
// Contents:
//   PAR_ODD / PAR_EVEN  parity mode encodings for the o_e input
//   MAX_DATA_W          widest word lane_parity() can address (DATA_W must not exceed it)
//   MAX_CNT_W           widest counter sat_inc() can handle (CNT_W must not exceed it)
//   lane_parity()       XOR of one lane of a word
//   sat_inc()           saturating increment for a counter of a given width
//
// Optional feature macro used by the top: PARITY_CHECK_LANE_CNT_EN.

package parity_check_pkg;

  localparam logic PAR_ODD  = 1'b0;
  localparam logic PAR_EVEN = 1'b1;

  localparam int unsigned MAX_DATA_W = 256;
  localparam int unsigned MAX_CNT_W  = 32;

  // XOR of bits [lane*lane_w +: lane_w] of data; callers zero-extend narrower words.
  function automatic logic lane_parity(input logic [MAX_DATA_W-1:0] data,
                                       input int unsigned           lane,
                                       input int unsigned           lane_w);
    logic p;
    p = 1'b0;
    for (int unsigned j = 0; j < MAX_DATA_W; j++) begin
      if ((j >= lane * lane_w) && (j < (lane + 1) * lane_w)) begin
        p = p ^ data[j];
      end
    end
    return p;
  endfunction

  // Increment val, holding at the all-ones value of a w-bit counter.
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] val,
                                                   input int unsigned          w);
    logic [MAX_CNT_W-1:0] max_val;
    if (w >= MAX_CNT_W) begin
      max_val = '1;
    end else begin
      max_val = (MAX_CNT_W'(1) << w) - MAX_CNT_W'(1);
    end
    return (val >= max_val) ? val : val + MAX_CNT_W'(1);
  endfunction

endpackage

// File: rtl/parity_lane_check.sv
// Combinational parity check of a single lane.
//
// Ports:
//   i_data  lane data slice (LANE_W bits)
//   i_par   received parity bit for this lane
//   i_e     parity mode: PAR_ODD (0) or PAR_EVEN (1)
//   o_err   1 when the received parity disagrees with the mode-adjusted XOR

module parity_lane_check
  import parity_check_pkg::*;
#(
  parameter int unsigned LANE_W = 8
) (
  input  logic [LANE_W-1:0] i_data,
  input  logic              i_par,
  input  logic              i_e,
  output logic              o_err
);

  logic w_gen;

  assign w_gen = lane_parity(MAX_DATA_W'(i_data), 0, LANE_W);

  always_comb begin
    o_err = 1'b0;
    if (i_e == PAR_EVEN) begin
      o_err = (i_par != w_gen);
    end else begin
      // Odd mode: the parity bit makes the total count of ones odd.
      o_err = (i_par != ~w_gen);
    end
  end

endmodule

// File: rtl/parity_check_stream.sv
// Pipelined parity checker for a streamed word split into LANES parity groups.
// One register stage with valid/ready flow control; full throughput when the
// consumer keeps out_ready high. Also keeps a sticky error flag and a saturating
// per-word error counter, both updated on the accept cycle.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   in_valid       input word valid
//   in_ready       checker can accept a word (~out_valid | out_ready)
//   in_data        data word, DATA_W bits
//   in_par         received parity, one bit per lane
//   o_e            parity mode for this word: 0 = odd, 1 = even
//   out_valid      result valid
//   out_ready      downstream accepts result
//   out_data       registered copy of the checked word
//   out_lane_err   per-lane mismatch mask
//   out_match      all lanes correct
//   out_mismatch   any lane wrong
//   err_sticky     set by any accepted erroneous word
//   err_cnt        saturating count of erroneous words
//   clr_err        synchronous clear of err_sticky / err_cnt (wins over increment)
//   lane_err_cnt   per-lane saturating error counters, CNT_W bits each
//                  (present only when PARITY_CHECK_LANE_CNT_EN is defined)

module parity_check_stream
  import parity_check_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [LANES-1:0]  in_par,
  input  logic              o_e,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LANES-1:0]  out_lane_err,
  output logic              out_match,
  output logic              out_mismatch,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              clr_err
`ifdef PARITY_CHECK_LANE_CNT_EN
  ,
  output logic [LANES*CNT_W-1:0] lane_err_cnt
`endif
);

  localparam int unsigned LANE_W = DATA_W / LANES;

  // ---------------------------------------------------------------------------
  // Per-lane combinational check
  // ---------------------------------------------------------------------------
  logic [LANES-1:0] w_lane_err;
  logic             w_any_err;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    parity_lane_check #(
      .LANE_W (LANE_W)
    ) u_lane (
      .i_data (in_data[gi*LANE_W +: LANE_W]),
      .i_par  (in_par[gi]),
      .i_e    (o_e),
      .o_err  (w_lane_err[gi])
    );
  end

  assign w_any_err = |w_lane_err;

  // ---------------------------------------------------------------------------
  // Handshake and output register
  // ---------------------------------------------------------------------------
  logic              r_out_valid, r_out_valid_d;
  logic [DATA_W-1:0] r_out_data, r_out_data_d;
  logic [LANES-1:0]  r_lane_err, r_lane_err_d;
  logic              r_match, r_match_d;
  logic              r_mismatch, r_mismatch_d;
  logic              w_accept;

  assign in_ready = ~r_out_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  always_comb begin
    r_out_valid_d = r_out_valid;
    r_out_data_d  = r_out_data;
    r_lane_err_d  = r_lane_err;
    r_match_d     = r_match;
    r_mismatch_d  = r_mismatch;
    if (w_accept) begin
      // Covers both an idle load and a pop+accept in the same cycle.
      r_out_valid_d = 1'b1;
      r_out_data_d  = in_data;
      r_lane_err_d  = w_lane_err;
      r_match_d     = ~w_any_err;
      r_mismatch_d  = w_any_err;
    end else if (r_out_valid && out_ready) begin
      r_out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_lane_err  <= '0;
      r_match     <= 1'b0;
      r_mismatch  <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid_d;
      r_out_data  <= r_out_data_d;
      r_lane_err  <= r_lane_err_d;
      r_match     <= r_match_d;
      r_mismatch  <= r_mismatch_d;
    end
  end

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_lane_err = r_lane_err;
  assign out_match    = r_match;
  assign out_mismatch = r_mismatch;

  // ---------------------------------------------------------------------------
  // Status: sticky flag and per-word error counter
  // ---------------------------------------------------------------------------
  logic             r_sticky, r_sticky_d;
  logic [CNT_W-1:0] r_err_cnt, r_err_cnt_d;

  always_comb begin
    r_sticky_d  = r_sticky;
    r_err_cnt_d = r_err_cnt;
    if (clr_err) begin
      // Clear wins: an erroneous word accepted in this cycle is not counted.
      r_sticky_d  = 1'b0;
      r_err_cnt_d = '0;
    end else if (w_accept && w_any_err) begin
      r_sticky_d  = 1'b1;
      r_err_cnt_d = CNT_W'(sat_inc(MAX_CNT_W'(r_err_cnt), CNT_W));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky  <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_sticky  <= r_sticky_d;
      r_err_cnt <= r_err_cnt_d;
    end
  end

  assign err_sticky = r_sticky;
  assign err_cnt    = r_err_cnt;

`ifdef PARITY_CHECK_LANE_CNT_EN
  // ---------------------------------------------------------------------------
  // Per-lane saturating error counters
  // ---------------------------------------------------------------------------
  logic [LANES-1:0][CNT_W-1:0] r_lane_cnt, r_lane_cnt_d;

  always_comb begin
    r_lane_cnt_d = r_lane_cnt;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (clr_err) begin
        r_lane_cnt_d[i] = '0;
      end else if (w_accept && w_lane_err[i]) begin
        r_lane_cnt_d[i] = CNT_W'(sat_inc(MAX_CNT_W'(r_lane_cnt[i]), CNT_W));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane_cnt <= '0;
    end else begin
      r_lane_cnt <= r_lane_cnt_d;
    end
  end

  assign lane_err_cnt = r_lane_cnt;
`endif

endmodule

// File: tb/tb_parity_check_stream.sv
module tb_parity_check_stream;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CNT3_W = 3;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [LANES-1:0]  in_par;
  logic              o_e;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [LANES-1:0]  out_lane_err;
  logic              out_match;
  logic              out_mismatch;
  logic              err_sticky;
  logic [CNT_W-1:0]  err_cnt;
  logic              clr_err;

  // Second instance with a 3-bit counter, sharing the input stimulus.
  logic              in_ready3;
  logic              out_valid3;
  logic [DATA_W-1:0] out_data3;
  logic [LANES-1:0]  out_lane_err3;
  logic              out_match3;
  logic              out_mismatch3;
  logic              err_sticky3;
  logic [CNT3_W-1:0] err_cnt3;

`ifdef PARITY_CHECK_LANE_CNT_EN
  logic [LANES*CNT_W-1:0]  lane_err_cnt;
  logic [LANES*CNT3_W-1:0] lane_err_cnt3;
`endif

  parity_check_stream #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_par       (in_par),
    .o_e          (o_e),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_lane_err (out_lane_err),
    .out_match    (out_match),
    .out_mismatch (out_mismatch),
    .err_sticky   (err_sticky),
    .err_cnt      (err_cnt),
    .clr_err      (clr_err)
`ifdef PARITY_CHECK_LANE_CNT_EN
    ,
    .lane_err_cnt (lane_err_cnt)
`endif
  );

  parity_check_stream #(
    .DATA_W (DATA_W),
    .LANES  (LANES),
    .CNT_W  (CNT3_W)
  ) dut3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready3),
    .in_data      (in_data),
    .in_par       (in_par),
    .o_e          (o_e),
    .out_valid    (out_valid3),
    .out_ready    (out_ready),
    .out_data     (out_data3),
    .out_lane_err (out_lane_err3),
    .out_match    (out_match3),
    .out_mismatch (out_mismatch3),
    .err_sticky   (err_sticky3),
    .err_cnt      (err_cnt3),
    .clr_err      (clr_err)
`ifdef PARITY_CHECK_LANE_CNT_EN
    ,
    .lane_err_cnt (lane_err_cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] p, input logic m);
    in_valid = v;
    in_data  = d;
    in_par   = p;
    o_e      = m;
  endtask

  typedef struct {
    logic [31:0] data;
    logic [3:0]  par;
    logic        mode;
    logic [3:0]  err;
  } vec_t;

  vec_t vecs[10];

  int unsigned m_cnt;
  logic        m_sticky;
  logic [7:0]  b;
  logic [31:0] w;
  logic [3:0]  p;

  initial begin
    // Hand-computed: lane XORs of 32'h010300FF are {1,0,0,0} (lane 3..0).
    vecs[0] = '{32'h010300FF, 4'b1000, 1'b1, 4'h0};
    vecs[1] = '{32'h010300FF, 4'b1000, 1'b0, 4'hF};
    vecs[2] = '{32'h00000000, 4'b0000, 1'b1, 4'h0};
    vecs[3] = '{32'h00000000, 4'b0000, 1'b0, 4'hF};
    vecs[4] = '{32'h00000000, 4'b1111, 1'b0, 4'h0};
    // 32'h80000001: lane XORs {1,0,0,1}
    vecs[5] = '{32'h80000001, 4'b1001, 1'b1, 4'h0};
    vecs[6] = '{32'h80000001, 4'b1101, 1'b1, 4'b0100};
    // 32'hFFFFFFFF: lane XORs all 0
    vecs[7] = '{32'hFFFFFFFF, 4'b0011, 1'b1, 4'b0011};
    // 32'h12345678: lane XORs {0,1,0,0}; odd parity bits are {1,0,1,1}
    vecs[8] = '{32'h12345678, 4'b1011, 1'b0, 4'h0};
    vecs[9] = '{32'h12345678, 4'b0011, 1'b0, 4'b1000};

    total     = 0;
    bad       = 0;
    m_cnt     = 0;
    m_sticky  = 1'b0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    clr_err   = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_lane_err", 64'(out_lane_err), 64'd0);
    chk("rst_match", 64'(out_match), 64'd0);
    chk("rst_mismatch", 64'(out_mismatch), 64'd0);
    chk("rst_sticky", 64'(err_sticky), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Table-driven single-word checks with out_ready held high.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].data, vecs[i].par, vecs[i].mode);
      step();
      if (vecs[i].err != 4'h0) begin
        m_cnt++;
        m_sticky = 1'b1;
      end
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].data));
      chk($sformatf("vec%0d_lane_err", i), 64'(out_lane_err), 64'(vecs[i].err));
      chk($sformatf("vec%0d_match", i), 64'(out_match), 64'(vecs[i].err == 4'h0));
      chk($sformatf("vec%0d_mismatch", i), 64'(out_mismatch), 64'(vecs[i].err != 4'h0));
      chk($sformatf("vec%0d_err_cnt", i), 64'(err_cnt), 64'(m_cnt));
      chk($sformatf("vec%0d_sticky", i), 64'(err_sticky), 64'(m_sticky));
      chk($sformatf("vec%0d_err_cnt3", i), 64'(err_cnt3), 64'(m_cnt));
    end
    drive(1'b0, '0, '0, 1'b0);
    step();
    chk("pop_clears_valid", 64'(out_valid), 64'd0);

    // Backpressure: word A accepted, then 3 stalled cycles with word B waiting.
    drive(1'b1, 32'h010300FF, 4'b1000, 1'b1);
    step();
    chk("bp_a_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b0;
    drive(1'b1, 32'h12345678, 4'b0100, 1'b1);
    #1;
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp_hold%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("bp_hold%0d_data", i), 64'(out_data), 64'h010300FF);
      chk($sformatf("bp_hold%0d_in_ready", i), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    step();
    chk("bp_b_valid", 64'(out_valid), 64'd1);
    chk("bp_b_data", 64'(out_data), 64'h12345678);
    chk("bp_b_match", 64'(out_match), 64'd1);
    drive(1'b0, '0, '0, 1'b0);
    step();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Back-to-back streaming: one result per cycle.
    for (int k = 0; k < 8; k++) begin
      b = 8'(k);
      w = {4{b}};
      p = {4{^b}};
      drive(1'b1, w, p, 1'b1);
      step();
      chk($sformatf("stream%0d_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("stream%0d_data", k), 64'(out_data), 64'(w));
      chk($sformatf("stream%0d_match", k), 64'(out_match), 64'd1);
    end
    drive(1'b0, '0, '0, 1'b0);
    step();
    chk("stream_err_cnt", 64'(err_cnt), 64'(m_cnt));

    // clr_err in the same cycle as an erroneous accept.
    clr_err = 1'b1;
    drive(1'b1, 32'h010300FF, 4'b1000, 1'b0);
    step();
    clr_err = 1'b0;
    chk("clr_err_cnt", 64'(err_cnt), 64'd0);
    chk("clr_sticky", 64'(err_sticky), 64'd0);
    chk("clr_mismatch", 64'(out_mismatch), 64'd1);
    chk("clr_lane_err", 64'(out_lane_err), 64'hF);

    // Saturation: 10 erroneous words, 3-bit counter stops at 7.
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 6) begin
        chk("sat_cnt3_at7", 64'(err_cnt3), 64'd7);
      end
    end
    drive(1'b0, '0, '0, 1'b0);
    step();
    chk("sat_cnt3_final", 64'(err_cnt3), 64'd7);
    chk("sat_cnt16_final", 64'(err_cnt), 64'd10);
    chk("sat_sticky", 64'(err_sticky), 64'd1);

    // Lane 2 only errs, 5 times.
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("clr_idle_cnt", 64'(err_cnt), 64'd0);
    drive(1'b1, 32'h00000000, 4'b0100, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("lane2_%0d_err", k), 64'(out_lane_err), 64'b0100);
    end
    drive(1'b0, '0, '0, 1'b0);
    step();
    chk("lane2_word_cnt", 64'(err_cnt), 64'd5);
`ifdef PARITY_CHECK_LANE_CNT_EN
    chk("lane_cnt0", 64'(lane_err_cnt[0*CNT_W +: CNT_W]), 64'd0);
    chk("lane_cnt1", 64'(lane_err_cnt[1*CNT_W +: CNT_W]), 64'd0);
    chk("lane_cnt2", 64'(lane_err_cnt[2*CNT_W +: CNT_W]), 64'd5);
    chk("lane_cnt3", 64'(lane_err_cnt[3*CNT_W +: CNT_W]), 64'd0);
    chk("lane_cnt3w_2", 64'(lane_err_cnt3[2*CNT3_W +: CNT3_W]), 64'd5);
`endif

    // Asynchronous reset while a result is stalled.
    out_ready = 1'b0;
    drive(1'b1, 32'h010300FF, 4'b1000, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    chk("arst_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_data", 64'(out_data), 64'd0);
    chk("arst_mismatch", 64'(out_mismatch), 64'd0);
    chk("arst_err_cnt", 64'(err_cnt), 64'd0);
    chk("arst_sticky", 64'(err_sticky), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
`ifdef PARITY_CHECK_LANE_CNT_EN
    chk("arst_lane_cnt", 64'(lane_err_cnt), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parity_check_stream.md
Name: parity_check_stream

Overview:
- Pipelined, parametrised parity checker for a streamed data word split into LANES equal parity groups (e.g. one parity bit per byte).
- Each lane's received parity bit is checked against the locally generated XOR, under a selectable odd/even mode.
- Per-lane error masks are registered and forwarded with valid/ready flow control.
- Sits between a link receiver and downstream consumers; it also keeps a sticky error flag and a saturating error counter for status readout.

Parameters:
- DATA_W, 32, data word width in bits; must be a multiple of LANES.
- LANES, 4, number of parity groups; lane i covers bits [i*(DATA_W/LANES) +: DATA_W/LANES].
- CNT_W, 16, error counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  input word valid.
- in_ready  out  1  checker can accept a word.
- in_data  in  DATA_W  data word.
- in_par  in  LANES  received parity, one bit per lane.
- o_e  in  1  parity mode: 0 = odd, 1 = even. Sampled with each accepted word.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATA_W  registered copy of the checked word.
- out_lane_err  out  LANES  per-lane mismatch mask.
- out_match  out  1  all lanes correct.
- out_mismatch  out  1  any lane wrong; always equals ~out_match while out_valid is high.
- err_sticky  out  1  set on any accepted erroneous word.
- err_cnt  out  CNT_W  count of erroneous words (one increment per word, not per lane).
- clr_err  in  1  synchronous clear of err_sticky and err_cnt.

Behaviour:
- Reset (asynchronous, rst_n low): out_valid=0, out_data=0, out_lane_err=0, out_match=0, out_mismatch=0, err_sticky=0, err_cnt=0.
- Lane check, per lane i: g = XOR of the lane bits.
  - Even mode (o_e=1): error when in_par[i] != g.
  - Odd mode (o_e=0): error when in_par[i] != ~g.
- Handshake:
  - in_ready = ~out_valid | out_ready, combinational from the output side.
  - Accept on in_valid & in_ready.
  - Output register loads on accept, which gives 1-cycle latency.
  - out_valid is cleared on out_valid & out_ready with no accept in the same cycle.
  - Outputs hold stable while out_valid & ~out_ready.
  - A simultaneous pop and accept in one cycle gives full throughput of 1 word/cycle.
- in_valid must not depend on in_ready. in_data, in_par and o_e are don't-care when in_valid=0.
- Flag and counter update happens on the accept cycle, not the output cycle.
  - err_sticky is set if any lane errs.
  - err_cnt increments by 1 and saturates at 2^CNT_W-1 (no wrap).
- clr_err priority:
  - clr_err has priority over the same-cycle increment: both go to 0 and that word's error is discarded.
  - out_* fields are unaffected by clr_err.
- Reset mid-transfer drops the in-flight result; no partial state survives.

Optional Feature:
- Macro: PARITY_CHECK_LANE_CNT_EN.
- Defined:
  - Adds output lane_err_cnt [LANES*CNT_W].
  - One saturating counter per lane, incremented when that lane errs on accept.
  - Cleared by clr_err and reset.
- Undefined: the port and the counters are absent; err_cnt behaviour is unchanged.

Decomposition:
- Package parity_check_pkg holds:
  - Mode constants PAR_ODD=1'b0 and PAR_EVEN=1'b1.
  - Function lane_parity(data, lane, lane_w).
  - Saturating-increment function sat_inc.
- One sub-module, parity_lane_check: combinational check of one lane (data slice, par bit, o_e -> err). It is instantiated LANES times via generate.
- Output register, handshake and counters stay in the top.

Test Plan:
- Even mode, DATA_W=32, LANES=4, in_data=32'h01_03_00_FF, in_par=4'b1000, o_e=1, out_ready=1 -> next cycle out_valid=1, out_lane_err=0, out_match=1, err_cnt=0.
- Same word with o_e=0 -> out_lane_err=4'hF, out_mismatch=1, err_sticky=1, err_cnt=1.
- Backpressure: out_ready=0 for 3 cycles after one accept -> in_ready=0, outputs hold; a second word is accepted only in the cycle out_ready returns to 1. Back-to-back streaming of 8 words with out_ready=1 -> 8 results in 8 cycles.
- Saturation: CNT_W=3, 10 erroneous words -> err_cnt stops at 7.
- clr_err asserted in the same cycle as an erroneous accept -> err_cnt=0, err_sticky=0, out_mismatch=1 on the output.
- Assert rst_n=0 while out_valid=1 and out_ready=0 -> out_valid=0 immediately (asynchronous). With PARITY_CHECK_LANE_CNT_EN defined, lane 2 flipped 5 times -> lane_err_cnt lane 2 = 5, other lanes = 0.
